// File: rtl/pipeline_interlock.sv
// pipeline_interlock: RAW hazard interlock for a 5-stage datapath with no forwarding.
// Ports:
//   clk, reset     clock and synchronous active-low reset
//   valid_d        decode register holds a real instruction
//   src1_d/src2_d  decode source registers, qualified by use_src1_d/use_src2_d
//   dest_d         decode destination, qualified by regwrite_d
//   branch_d       taken branch resolved in decode
//   enable         PC/decode advance (0 = hold)
//   flushC         execute register loads a bubble
//   flush_decode   decode register clears on the next edge
//   stall_count    saturating total of stall cycles
//   interlock_err  sticky: a stall run exceeded MAX_STALL
module pipeline_interlock #(
    parameter int AW                 = 4,
    parameter int CNT_W              = 16,
    parameter int MAX_STALL          = 3,
    parameter int ZERO_REG_HARDWIRED = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_d,
    input  logic [AW-1:0]    src1_d,
    input  logic [AW-1:0]    src2_d,
    input  logic             use_src1_d,
    input  logic             use_src2_d,
    input  logic [AW-1:0]    dest_d,
    input  logic             regwrite_d,
    input  logic             branch_d,
    output logic             enable,
    output logic             flushC,
    output logic             flush_decode,
    output logic [CNT_W-1:0] stall_count,
    output logic             interlock_err
);
    localparam logic [CNT_W-1:0] SAT = '1;
    // scoreboard index 0 = E, 1 = M, 2 = W
    logic [2:0]         sb_v_q, sb_v_d;
    logic [2:0][AW-1:0] sb_dst_q, sb_dst_d;
    logic [CNT_W-1:0]   run_len_q, run_len_d, stall_cnt_q, stall_cnt_d;
    logic               err_q, err_d;
    logic               hit1, hit2, hazard, wr_issue;
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            hit1 = hit1 | (sb_v_q[k] & (sb_dst_q[k] == src1_d));
            hit2 = hit2 | (sb_v_q[k] & (sb_dst_q[k] == src2_d));
        end
        if (ZERO_REG_HARDWIRED != 0) begin
            hit1 = hit1 & (src1_d != {AW{1'b0}});
            hit2 = hit2 & (src2_d != {AW{1'b0}});
        end
        hazard   = valid_d & ((use_src1_d & hit1) | (use_src2_d & hit2));
        wr_issue = valid_d & ~hazard & regwrite_d;
    end
    // reset forces the datapath into hold with bubbles in both E and decode
    assign enable        = reset ? ~hazard : 1'b0;
    assign flushC        = reset ? (hazard | ~valid_d) : 1'b1;
    assign flush_decode  = reset ? (branch_d & valid_d & ~hazard) : 1'b1;
    assign stall_count   = stall_cnt_q;
    assign interlock_err = err_q;
    always_comb begin
        // unconditional shift: stalls inject bubbles while older entries drain
        sb_v_d      = {sb_v_q[1:0], wr_issue};
        sb_dst_d    = {sb_dst_q[1:0], wr_issue ? dest_d : {AW{1'b0}}};
        run_len_d   = !hazard ? '0 : (run_len_q == SAT ? run_len_q : run_len_q + CNT_W'(1));
        stall_cnt_d = (hazard && stall_cnt_q != SAT) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        err_d       = err_q | (hazard & (int'(run_len_q) >= MAX_STALL));
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            sb_v_q      <= '0;
            sb_dst_q    <= '0;
            run_len_q   <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            sb_v_q      <= sb_v_d;
            sb_dst_q    <= sb_dst_d;
            run_len_q   <= run_len_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_pipeline_interlock.sv
// tb_pipeline_interlock: randomized and directed checks of three interlock configurations against a pending-write timestamp model.
module tb_pipeline_interlock;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0, ua = 1'b0, ub = 1'b0, rw = 1'b0, br = 1'b0;
    logic [3:0] sa = '0, sb = '0, dst = '0;
    wire  [2:0] en_w, fc_w, fd_w, err_w;
    wire  [15:0] sc0, sc1;
    wire  [1:0]  sc2;

    always #5 clk = ~clk;

    pipeline_interlock u0 (.clk(clk), .reset(rst_n), .valid_d(valid), .src1_d(sa), .src2_d(sb),
        .use_src1_d(ua), .use_src2_d(ub), .dest_d(dst), .regwrite_d(rw), .branch_d(br),
        .enable(en_w[0]), .flushC(fc_w[0]), .flush_decode(fd_w[0]), .stall_count(sc0), .interlock_err(err_w[0]));
    pipeline_interlock #(.ZERO_REG_HARDWIRED(1)) u1 (.clk(clk), .reset(rst_n), .valid_d(valid), .src1_d(sa), .src2_d(sb),
        .use_src1_d(ua), .use_src2_d(ub), .dest_d(dst), .regwrite_d(rw), .branch_d(br),
        .enable(en_w[1]), .flushC(fc_w[1]), .flush_decode(fd_w[1]), .stall_count(sc1), .interlock_err(err_w[1]));
    pipeline_interlock #(.MAX_STALL(1), .CNT_W(2)) u2 (.clk(clk), .reset(rst_n), .valid_d(valid), .src1_d(sa), .src2_d(sb),
        .use_src1_d(ua), .use_src2_d(ub), .dest_d(dst), .regwrite_d(rw), .branch_d(br),
        .enable(en_w[2]), .flushC(fc_w[2]), .flush_decode(fd_w[2]), .stall_count(sc2), .interlock_err(err_w[2]));

    // per-instance configuration
    int zr[3]   = '{0, 1, 0};
    int maxs[3] = '{3, 3, 1};
    int cmax[3] = '{65535, 65535, 3};
    // model: cycle at which each register's most recent write issued
    int last_wr[3][16];
    int m_run[3], m_cnt[3], m_err[3];
    int cyc = 0;
    int n_chk = 0, n_err = 0;
    int nst[3], nfd[3];
    logic last_en0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // a write issued at cycle c stays unreadable until cycle c+4 (E, M, W then visible)
    function automatic bit pend(int i, logic [3:0] a);
        return !(zr[i] != 0 && a == 0) && (cyc - last_wr[i][a] <= 3);
    endfunction

    function automatic int scv(int i);
        return i == 0 ? int'(sc0) : i == 1 ? int'(sc1) : int'(sc2);
    endfunction

    task automatic step(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic u1, input logic u2, input logic [3:0] d, input logic w, input logic bra);
        bit hz;
        rst_n = r; valid = v; sa = a; sb = b; ua = u1; ub = u2; dst = d; rw = w; br = bra;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            hz = rst_n && valid && ((ua && pend(i, sa)) || (ub && pend(i, sb)));
            check($sformatf("enable[%0d]", i), int'(en_w[i]), rst_n ? int'(!hz) : 0);
            check($sformatf("flushC[%0d]", i), int'(fc_w[i]), rst_n ? int'(hz || !valid) : 1);
            check($sformatf("flush_decode[%0d]", i), int'(fd_w[i]), rst_n ? int'(br && valid && !hz) : 1);
            check($sformatf("stall_count[%0d]", i), scv(i), m_cnt[i]);
            check($sformatf("interlock_err[%0d]", i), int'(err_w[i]), m_err[i]);
            if (rst_n && !en_w[i]) nst[i]++;
            if (rst_n && fd_w[i]) nfd[i]++;
            if (!rst_n) begin
                for (int k = 0; k < 16; k++) last_wr[i][k] = -100;
                m_run[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
            end else if (hz) begin
                if (m_run[i] >= maxs[i]) m_err[i] = 1;
                m_run[i] = m_run[i] < cmax[i] ? m_run[i] + 1 : m_run[i];
                m_cnt[i] = m_cnt[i] < cmax[i] ? m_cnt[i] + 1 : m_cnt[i];
            end else begin
                m_run[i] = 0;
                if (valid && rw) last_wr[i][dst] = cyc;
            end
        end
        last_en0 = en_w[0];
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // hold one instruction in decode until instance 0 lets it issue
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic u1, input logic u2,
                         input logic [3:0] d, input logic w, input logic bra);
        bit done = 0;
        for (int i = 0; i < 3; i++) begin nst[i] = 0; nfd[i] = 0; end
        for (int t = 0; t < 8 && !done; t++) begin
            step(1, 1, a, b, u1, u2, d, w, bra);
            done = last_en0;
        end
        if (!done) check("issue_timeout", 0, 1);
    endtask

    task automatic nops(input int n);
        for (int k = 0; k < n; k++) issue(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 16; k++) last_wr[i][k] = -100;
            m_run[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
        end
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0);
        check("release_stalls", nst[0], 0);
        check("release_count", int'(sc0), 0);
        // distance-1 RAW through src1
        issue(0, 0, 0, 0, 5, 1, 0);
        issue(5, 0, 1, 0, 0, 0, 0);
        check("raw_d1_stalls", nst[0], 3);
        check("raw_d1_count", int'(sc0), 3);
        check("raw_d1_err", int'(err_w[0]), 0);
        nops(3);
        // distance-2 RAW through src2
        issue(0, 0, 0, 0, 7, 1, 0);
        issue(0, 0, 0, 0, 1, 1, 0);
        issue(0, 7, 0, 1, 0, 0, 0);
        check("raw_d2_stalls", nst[0], 2);
        nops(3);
        // three independent instructions hide the producer
        issue(0, 0, 0, 0, 7, 1, 0);
        nops(3);
        issue(7, 0, 1, 0, 0, 0, 0);
        check("raw_d4_stalls", nst[0], 0);
        nops(3);
        // r0 dependency: hardwired zero instance never stalls
        issue(0, 0, 0, 0, 0, 1, 0);
        issue(0, 0, 1, 0, 0, 0, 0);
        check("r0_stalls_plain", nst[0], 3);
        check("r0_stalls_hardwired", nst[1], 0);
        nops(3);
        // taken branch without hazard
        issue(0, 0, 0, 0, 0, 0, 1);
        check("br_stalls", nst[0], 0);
        check("br_flush_cycles", nfd[0], 1);
        nops(3);
        // taken branch depending on the previous instruction
        issue(0, 0, 0, 0, 3, 1, 0);
        issue(3, 0, 1, 0, 0, 0, 1);
        check("br_dep_stalls", nst[0], 3);
        check("br_dep_flush_cycles", nfd[0], 1);
        nops(3);
        // repeated RAW pairs: MAX_STALL=1 instance errors and its 2-bit count saturates
        for (int k = 0; k < 3; k++) begin
            issue(0, 0, 0, 0, 9, 1, 0);
            issue(9, 0, 1, 0, 0, 0, 0);
        end
        check("err_strict", int'(err_w[2]), 1);
        check("count_sat", int'(sc2), 3);
        check("err_lenient", int'(err_w[0]), 0);
        // reset mid-stall clears the scoreboard
        issue(0, 0, 0, 0, 4, 1, 0);
        step(1, 1, 4, 0, 1, 0, 0, 0, 0);
        step(0, 1, 4, 0, 1, 0, 0, 0, 0);
        check("err_cleared", int'(err_w[2]), 0);
        issue(4, 0, 1, 0, 0, 0, 0);
        check("post_reset_stalls", nst[0], 0);
        // randomized traffic on a small register set to provoke hazards
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 49) != 0, $urandom_range(0, 4) != 0,
                 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
